iterative_shift_left: RTL and testbench

//  Multi-cycle logical left shifter. Uses a valid/ready handshake on both input and output.

---
 rtl/iterative_shift_left.sv | 95 +++++++++
 tb/tb_iterative_shift_left.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/iterative_shift_left.sv
// Multi-cycle logical left shifter: one shift-amount bit per cycle, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module iterative_shift_left #(
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("iterative_shift_left: WIDTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [SHW-1:0]   shamt_q;
  logic [SHW-1:0]   k_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             last_stage_c;

  // One zero-fill stage: shift by 2^k when shamt bit k is set.
  always_comb begin
    data_d = data_q;
    if (shamt_q[k_q]) begin
      data_d = data_q << (SHW'(1) << k_q);
    end
  end

  assign last_stage_c = (k_q == SHW'(SHW - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      shamt_q     <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= in_data;
            shamt_q    <= in_shamt;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          data_q <= data_d;
          k_q    <= k_q + SHW'(1);
          if (last_stage_c) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Result and flags hold until the consumer takes it.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_iterative_shift_left.sv
// Scoreboard bench for iterative_shift_left at WIDTH=8: directed ops push expected
// results, a negedge monitor pops and compares on every output handshake.
module tb_iterative_shift_left;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SHW   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int outputs_seen = 0;
  logic [WIDTH-1:0] exp_q[$];

  iterative_shift_left #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: a transfer happens on the next posedge when both valid and ready are high.
  initial begin
    logic [WIDTH-1:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        outputs_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
        end else begin
          exp = exp_q.pop_front();
          chk("result", 32'(out_data), 32'(exp));
        end
      end
    end
  end

  // Present one op and wait for its acceptance edge; returns the cycle of acceptance.
  task automatic issue(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                       input logic [WIDTH-1:0] exp, input bit push, output int acc_cycle);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    if (push) exp_q.push_back(exp);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    acc_cycle = cycle;
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  // Full op with latency checks: out_valid must rise exactly on the third edge after accept.
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                        input logic [WIDTH-1:0] exp);
    int acc;
    issue(d, s, exp, 1'b1, acc);
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("latency_E%0d_out_valid", e), 32'(out_valid), 32'(e == 3));
      chk($sformatf("latency_E%0d_in_ready", e), 32'(in_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    chk("post_done_in_ready", 32'(in_ready), 32'(1));
    chk("post_done_out_valid", 32'(out_valid), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    out_ready = 1'b1;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_out_data", 32'(out_data), 32'(8'h00));
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Basic ops, including shamt=0 and MSB discard.
    run_op(8'h01, 3'd3, 8'h08);
    run_op(8'hFF, 3'd7, 8'h80);
    run_op(8'hA5, 3'd0, 8'hA5);
    run_op(8'h81, 3'd1, 8'h02);
    run_op(8'h5A, 3'd6, 8'h80);

    // Back-pressure: result must hold while out_ready is low, in_valid ignored.
    out_ready = 1'b0;
    issue(8'h5A, 3'd2, 8'h68, 1'b1, a0);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'hC3;
      in_shamt = 3'd1;
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_out_data", 32'(out_data), 32'(8'h68));
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_in_ready", 32'(in_ready), 32'(1));
    chk("stall_release_out_valid", 32'(out_valid), 32'(0));

    // Reset during SHIFT abandons the op.
    issue(8'h55, 3'd1, 8'h00, 1'b0, a0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midreset_out_valid", 32'(out_valid), 32'(0));
    chk("midreset_out_data", 32'(out_data), 32'(0));
    chk("midreset_in_ready", 32'(in_ready), 32'(1));
    run_op(8'h03, 3'd2, 8'h0C);

    // Back-to-back with in_valid held high: accepts exactly SHW+2 cycles apart.
    in_valid = 1'b1;
    issue(8'h11, 3'd4, 8'h10, 1'b1, a0);
    issue(8'h0F, 3'd5, 8'hE0, 1'b1, a1);
    chk("b2b_accept_spacing", 32'(a1 - a0), 32'(5));
    repeat (8) @(posedge clk);
    #1;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    chk("output_count", 32'(outputs_seen), 32'(9));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
